// File: rtl/surf_stream_pkg.sv
// surf_stream_pkg: shared FSM states and round-robin next-grant search for surf_stream_merge
package surf_stream_pkg;
  typedef enum logic [1:0] {IDLE, PASS, TERM} state_e;
  // First requester after last (wrapping modulo n); returns last itself when nothing requests
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] last, input int n);
    int idx;
    rr_next = last;
    for (int i = 16; i >= 1; i--) begin
      idx = (int'(last) + i) % n;
      if (i <= n && req[idx]) rr_next = 4'(idx);
    end
  endfunction
endpackage

// File: rtl/surf_stream_merge_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the next requester after last_grant
module rr_arbiter
  import surf_stream_pkg::*;
#(
  parameter int NCHAN = 7
) (
  input  logic [NCHAN-1:0]         request,
  input  logic [$clog2(NCHAN)-1:0] last_grant,
  output logic [$clog2(NCHAN)-1:0] next_grant,
  output logic                     valid
);
  localparam int GW = $clog2(NCHAN);
  assign next_grant = GW'(rr_next(16'(request), 4'(last_grant), NCHAN));
  assign valid = |request;
endmodule

// File: rtl/surf_stream_merge.sv
// surf_stream_merge: packet-atomic round-robin merge of NCHAN AXI4S streams into one registered master.
// Define SURF_STREAM_MERGE_WATCHDOG_EN to add the stalled-packet watchdog (TERM state, m_tuser, timeout_count_o).
module surf_stream_merge
  import surf_stream_pkg::*;
#(
  parameter int NCHAN          = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        sysclk_i,
  input  logic                        rst_i,
  input  logic [NCHAN*DATA_WIDTH-1:0] s_tdata,
  input  logic [NCHAN-1:0]            s_tvalid,
  output logic [NCHAN-1:0]            s_tready,
  input  logic [NCHAN-1:0]            s_tlast,
  input  logic [NCHAN-1:0]            enable_i,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic [$clog2(NCHAN)-1:0]    m_tdest,
  output logic                        m_tuser,
  output logic [31:0]                 pkt_count_o,
  output logic [15:0]                 timeout_count_o
);
  localparam int GW = $clog2(NCHAN);
  if (NCHAN < 2 || NCHAN > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("surf_stream_merge: parameter out of range");
  end
  state_e                state_q;
  logic [GW-1:0]         grant_q, arb_grant, m_tdest_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q, m_tlast_q, arb_valid, out_free, accept;
  logic [31:0]           pkt_count_q;
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
  logic                  m_tuser_q;
  logic [15:0]           timeout_count_q;
  logic [31:0]           wd_q;
`endif
  rr_arbiter #(.NCHAN(NCHAN)) u_arb (
    .request   (enable_i & s_tvalid),
    .last_grant(grant_q),
    .next_grant(arb_grant),
    .valid     (arb_valid)
  );
  assign out_free = !m_tvalid_q || m_tready;
  assign accept   = (state_q == PASS) && s_tvalid[grant_q] && out_free;
  assign s_tready = (state_q == PASS && out_free) ? NCHAN'(1) << grant_q : '0;
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= GW'(NCHAN - 1);
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      m_tdest_q   <= '0;
      pkt_count_q <= '0;
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
      m_tuser_q       <= 1'b0;
      timeout_count_q <= '0;
      wd_q            <= '0;
`endif
    end else begin
      if (m_tready) m_tvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (arb_valid) begin
          grant_q <= arb_grant;
          state_q <= PASS;
        end
        PASS: if (accept) begin
          m_tvalid_q <= 1'b1;
          m_tdata_q  <= s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
          m_tlast_q  <= s_tlast[grant_q];
          m_tdest_q  <= grant_q;
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
          m_tuser_q  <= 1'b0;
          wd_q       <= '0;
`endif
          if (s_tlast[grant_q]) begin
            state_q     <= IDLE;
            pkt_count_q <= pkt_count_q + 32'd1;
          end
        end
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
        else if (!s_tvalid[grant_q]) begin
          wd_q <= wd_q + 32'd1;
          if (wd_q == 32'(TIMEOUT_CYCLES - 1)) state_q <= TERM;
        end
        TERM: if (out_free) begin
          m_tvalid_q      <= 1'b1;
          m_tdata_q       <= '0;
          m_tlast_q       <= 1'b1;
          m_tuser_q       <= 1'b1;
          m_tdest_q       <= grant_q;
          timeout_count_q <= timeout_count_q + {15'd0, timeout_count_q != 16'hFFFF};
          pkt_count_q     <= pkt_count_q + 32'd1;
          wd_q            <= '0;
          state_q         <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = m_tdata_q;
  assign m_tlast     = m_tlast_q;
  assign m_tdest     = m_tdest_q;
  assign pkt_count_o = pkt_count_q;
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
  assign m_tuser         = m_tuser_q;
  assign timeout_count_o = timeout_count_q;
`else
  assign m_tuser         = 1'b0;
  assign timeout_count_o = '0;
`endif
endmodule

// File: tb/tb_surf_stream_merge.sv
// tb_surf_stream_merge: randomized and directed self-checking bench for surf_stream_merge
module tb_surf_stream_merge;
  localparam int NCH = 7, DW = 8, TO = 16;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NCH*DW-1:0] s_tdata = '0;
  logic [NCH-1:0] s_tvalid = '0, s_tready, s_tlast = '0, enable_i = '1;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic [2:0] m_tdest;
  logic [31:0] pkt_count_o;
  logic [15:0] timeout_count_o;
  always #5 clk = ~clk;

  surf_stream_merge #(.NCHAN(NCH), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk_i(clk), .rst_i(rst_i), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .enable_i(enable_i), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tdest(m_tdest), .m_tuser(m_tuser), .pkt_count_o(pkt_count_o),
    .timeout_count_o(timeout_count_o)
  );

  typedef struct packed {logic [2:0] dest; logic [7:0] data; logic last; logic user; logic [31:0] cyc;} beat_t;
  beat_t out_log[$];
  logic [8:0] src[NCH][$];
  logic [NCH-1:0] fired = '0;
  int cyc = 0, ck = 0, fails = 0, stab_err = 0, stall_n = 0, lat_err = 0, tready_mode = 0, gap_pct = 0;
  logic hold_pend = 1'b0, lat_pend = 1'b0;
  logic [13:0] hold_val;
  logic [12:0] lat_val;

  function automatic int pending();
    pending = 0;
    for (int k = 0; k < NCH; k++) pending += src[k].size();
  endfunction

  task automatic drive();
    for (int k = 0; k < NCH; k++) begin
      if (!(s_tvalid[k] && !fired[k])) s_tvalid[k] = src[k].size() > 0 && $urandom_range(99) >= gap_pct;
      s_tdata[k*DW +: DW] = src[k].size() > 0 ? src[k][0][7:0] : 8'h00;
      s_tlast[k] = src[k].size() > 0 && src[k][0][8];
    end
    fired = '0;
    if (tready_mode == 0) m_tready = 1'b1;
    else if (tready_mode == 1) m_tready = 1'($urandom_range(1));
    else if (tready_mode == 2) m_tready = !m_tready;
    else m_tready = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    fired = s_tvalid & s_tready;
    if (hold_pend) begin
      stall_n++;
      if ({m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser} !== hold_val) stab_err++;
    end
    if (lat_pend && {m_tvalid, m_tdest, m_tlast, m_tdata} !== lat_val) lat_err++;
    if (m_tvalid && m_tready) out_log.push_back({m_tdest, m_tdata, m_tlast, m_tuser, 32'(cyc)});
    hold_pend = m_tvalid && !m_tready;
    hold_val = {m_tvalid, m_tdata, m_tlast, m_tdest, m_tuser};
    lat_pend = 1'b0;
    for (int k = 0; k < NCH; k++) if (fired[k]) begin
      lat_pend = 1'b1;
      lat_val = {1'b1, 3'(k), src[k][0]};
      void'(src[k].pop_front());
    end
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < NCH; k++) src[k].delete();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; fired = '0; hold_pend = 1'b0; lat_pend = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_i = 1'b0;
    out_log.delete();
  endtask

  task automatic run_idle(input int bound, output bit to);
    to = 1'b1;
    for (int i = 0; i < bound && to; i++) begin
      tick();
      if (s_tvalid == '0 && !m_tvalid && pending() == 0) to = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    ck++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %0b, expected 0", m_tvalid); end
    ck++; if ({m_tlast, m_tdata, m_tdest, m_tuser} !== 13'h0) begin fails++; $display("FAIL reset_outputs: got %0h, expected 0", {m_tlast, m_tdata, m_tdest, m_tuser}); end
    ck++; if (s_tready !== '0) begin fails++; $display("FAIL reset_tready: got %0h, expected 0", s_tready); end
    ck++; if ({pkt_count_o, timeout_count_o} !== 48'h0) begin fails++; $display("FAIL reset_counters: got %0h, expected 0", {pkt_count_o, timeout_count_o}); end
  endtask

  task automatic test_single();
    bit to;
    int rise;
    logic [11:0] exp_b[3];
    exp_b = '{{3'd2, 8'hAA, 1'b0}, {3'd2, 8'hBB, 1'b0}, {3'd2, 8'hCC, 1'b1}};
    do_reset();
    tready_mode = 0; lat_err = 0;
    src[2].push_back({1'b0, 8'hAA}); src[2].push_back({1'b0, 8'hBB}); src[2].push_back({1'b1, 8'hCC});
    drive();
    rise = cyc;
    run_idle(50, to);
    ck++; if (to) begin fails++; $display("FAIL single_timeout: got busy, expected idle"); end
    ck++; if (out_log.size() != 3) begin fails++; $display("FAIL single_count: got %0d, expected 3", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 3; i++) begin
      ck++; if ({out_log[i].dest, out_log[i].data, out_log[i].last} !== exp_b[i]) begin fails++; $display("FAIL single_beat%0d: got %0h, expected %0h", i, {out_log[i].dest, out_log[i].data, out_log[i].last}, exp_b[i]); end
    end
    ck++; if (out_log.size() == 0 || out_log[0].cyc != 32'(rise + 2)) begin fails++; $display("FAIL single_latency: got %0d, expected %0d", out_log.size() ? int'(out_log[0].cyc) : -1, rise + 2); end
    ck++; if (pkt_count_o !== 32'd1) begin fails++; $display("FAIL single_pkt_count: got %0d, expected 1", pkt_count_o); end
    ck++; if (lat_err != 0) begin fails++; $display("FAIL single_stage: got %0d late beats, expected 0", lat_err); end
  endtask

  task automatic test_rr_order();
    bit to;
    int ch[3];
    logic [7:0] d[6];
    ch = '{0, 3, 6};
    do_reset();
    for (int j = 0; j < 3; j++) begin
      d[2*j] = 8'($urandom); d[2*j+1] = 8'($urandom);
      src[ch[j]].push_back({1'b0, d[2*j]}); src[ch[j]].push_back({1'b1, d[2*j+1]});
    end
    drive();
    run_idle(100, to);
    ck++; if (to || out_log.size() != 6) begin fails++; $display("FAIL rr_count: got %0d, expected 6", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 6; i++) begin
      ck++; if ({out_log[i].dest, out_log[i].data, out_log[i].last} !== {3'(ch[i/2]), d[i], 1'(i % 2)}) begin fails++; $display("FAIL rr_beat%0d: got %0h, expected %0h", i, {out_log[i].dest, out_log[i].data, out_log[i].last}, {3'(ch[i/2]), d[i], 1'(i % 2)}); end
    end
    ck++; if (out_log.size() != 6 || out_log[2].cyc - out_log[0].cyc != 3 || out_log[4].cyc - out_log[2].cyc != 3) begin fails++; $display("FAIL rr_throughput: got gaps other than 3, expected 3"); end
    out_log.delete();
    src[3].push_back({1'b1, 8'h33}); src[0].push_back({1'b1, 8'h00});
    drive();
    run_idle(50, to);
    ck++; if (to || out_log.size() != 2 || out_log[0].dest !== 3'd0 || out_log[1].dest !== 3'd3) begin fails++; $display("FAIL rr_refill: got %0d beats first dest %0d, expected 2 beats first dest 0", out_log.size(), out_log.size() ? out_log[0].dest : 3'd7); end
  endtask

  task automatic test_regrant();
    bit to;
    out_log.delete();
    for (int i = 0; i < 4; i++) src[5].push_back({1'(i % 2), 8'(8'h50 + i)});
    drive();
    run_idle(50, to);
    ck++; if (to || out_log.size() != 4) begin fails++; $display("FAIL regrant_count: got %0d, expected 4", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      ck++; if ({out_log[i].dest, out_log[i].data} !== {3'd5, 8'(8'h50 + i)}) begin fails++; $display("FAIL regrant_beat%0d: got %0h, expected %0h", i, {out_log[i].dest, out_log[i].data}, {3'd5, 8'(8'h50 + i)}); end
    end
    ck++; if (out_log.size() != 4 || out_log[2].cyc - out_log[0].cyc != 3) begin fails++; $display("FAIL regrant_gap: got wrong spacing, expected 3 cycles"); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [7:0] d[4];
    out_log.delete(); stab_err = 0; stall_n = 0; lat_err = 0; tready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      d[i] = 8'($urandom);
      src[1].push_back({i == 3, d[i]});
    end
    drive();
    run_idle(100, to);
    tready_mode = 0;
    ck++; if (to || out_log.size() != 4) begin fails++; $display("FAIL bp_count: got %0d, expected 4", out_log.size()); end
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      ck++; if ({out_log[i].dest, out_log[i].data, out_log[i].last} !== {3'd1, d[i], i == 3}) begin fails++; $display("FAIL bp_beat%0d: got %0h, expected %0h", i, {out_log[i].dest, out_log[i].data, out_log[i].last}, {3'd1, d[i], i == 3}); end
    end
    ck++; if (stab_err != 0 || stall_n == 0) begin fails++; $display("FAIL bp_stable: got %0d unstable of %0d stalls, expected 0 of >0", stab_err, stall_n); end
    ck++; if (lat_err != 0) begin fails++; $display("FAIL bp_stage: got %0d late beats, expected 0", lat_err); end
  endtask

  task automatic test_enable();
    bit to;
    int n4, n5;
    out_log.delete();
    enable_i = 7'h6F;
    src[4].push_back({1'b0, 8'h41}); src[4].push_back({1'b1, 8'h42});
    src[5].push_back({1'b0, 8'h51}); src[5].push_back({1'b0, 8'h52}); src[5].push_back({1'b1, 8'h53});
    drive();
    repeat (30) begin
      tick();
      if (out_log.size() > 0) enable_i[5] = 1'b0;
    end
    n4 = 0; n5 = 0;
    foreach (out_log[i]) begin
      if (out_log[i].dest == 3'd4) n4++;
      if (out_log[i].dest == 3'd5) begin
        ck++; if ({out_log[i].data, out_log[i].last} !== {8'(8'h51 + n5), n5 == 2}) begin fails++; $display("FAIL enable_ch5_beat%0d: got %0h, expected %0h", n5, {out_log[i].data, out_log[i].last}, {8'(8'h51 + n5), n5 == 2}); end
        n5++;
      end
    end
    ck++; if (n5 != 3) begin fails++; $display("FAIL enable_ch5_count: got %0d, expected 3", n5); end
    ck++; if (n4 != 0 || src[4].size() != 2) begin fails++; $display("FAIL enable_ch4_blocked: got %0d beats out, expected 0", n4); end
    out_log.delete();
    enable_i = '1;
    run_idle(50, to);
    ck++; if (to || out_log.size() != 2 || {out_log[0].dest, out_log[0].data, out_log[1].data} !== {3'd4, 8'h41, 8'h42}) begin fails++; $display("FAIL enable_ch4_release: got %0d beats, expected 2 from ch4", out_log.size()); end
  endtask

  task automatic test_random();
    bit to, open;
    int npk, base, len;
    logic [2:0] cur;
    logic [8:0] exp_q[NCH][$];
    logic [8:0] v;
    npk = 0; open = 1'b0; cur = '0;
    out_log.delete(); stab_err = 0; lat_err = 0; tready_mode = 1; gap_pct = 30; enable_i = '1;
    base = int'(pkt_count_o);
    for (int k = 0; k < NCH; k++)
      for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          v = {b == len - 1, 8'($urandom)};
          src[k].push_back(v);
          exp_q[k].push_back(v);
        end
        npk++;
      end
    drive();
    run_idle(3000, to);
    tready_mode = 0; gap_pct = 0;
    ck++; if (to) begin fails++; $display("FAIL rand_timeout: got %0d pending, expected drained", pending()); end
    foreach (out_log[i]) begin
      ck++;
      if (out_log[i].dest >= NCH || exp_q[out_log[i].dest].size() == 0) begin fails++; $display("FAIL rand_unexpected: got dest %0d data %0h, expected none", out_log[i].dest, out_log[i].data); end
      else begin
        v = exp_q[out_log[i].dest].pop_front();
        if ({out_log[i].last, out_log[i].data} !== v) begin fails++; $display("FAIL rand_beat%0d: got %0h, expected %0h", i, {out_log[i].last, out_log[i].data}, v); end
      end
      ck++; if (open && out_log[i].dest !== cur) begin fails++; $display("FAIL rand_interleave: got dest %0d, expected %0d", out_log[i].dest, cur); end
      open = !out_log[i].last; cur = out_log[i].dest;
    end
    for (int k = 0; k < NCH; k++) begin
      ck++; if (exp_q[k].size() != 0) begin fails++; $display("FAIL rand_missing_ch%0d: got %0d left, expected 0", k, exp_q[k].size()); end
    end
    ck++; if (int'(pkt_count_o) - base != npk) begin fails++; $display("FAIL rand_pkt_count: got %0d, expected %0d", int'(pkt_count_o) - base, npk); end
    ck++; if (stab_err != 0 || lat_err != 0) begin fails++; $display("FAIL rand_stage: got %0d unstable %0d late, expected 0", stab_err, lat_err); end
  endtask

  task automatic test_watchdog();
    bit to;
    do_reset();
    tready_mode = 0;
    src[0].push_back({1'b0, 8'h5A});
    drive();
`ifdef SURF_STREAM_MERGE_WATCHDOG_EN
    for (int i = 0; i < 100 && out_log.size() < 2; i++) tick();
    ck++; if (out_log.size() != 2) begin fails++; $display("FAIL wd_count: got %0d beats, expected 2", out_log.size()); end
    ck++; if ({out_log[0].dest, out_log[0].data, out_log[0].last, out_log[0].user} !== {3'd0, 8'h5A, 2'b00}) begin fails++; $display("FAIL wd_data_beat: got %0h, expected %0h", {out_log[0].dest, out_log[0].data, out_log[0].last, out_log[0].user}, {3'd0, 8'h5A, 2'b00}); end
    ck++; if ({out_log[1].dest, out_log[1].data, out_log[1].last, out_log[1].user} !== {3'd0, 8'h00, 2'b11}) begin fails++; $display("FAIL wd_term_beat: got %0h, expected %0h", {out_log[1].dest, out_log[1].data, out_log[1].last, out_log[1].user}, {3'd0, 8'h00, 2'b11}); end
    ck++; if (out_log[1].cyc - out_log[0].cyc != TO + 1) begin fails++; $display("FAIL wd_delay: got %0d, expected %0d", out_log[1].cyc - out_log[0].cyc, TO + 1); end
    ck++; if ({timeout_count_o, pkt_count_o} !== {16'd1, 32'd1}) begin fails++; $display("FAIL wd_counters: got %0d/%0d, expected 1/1", timeout_count_o, pkt_count_o); end
    out_log.delete();
    src[0].push_back({1'b1, 8'h33});
    drive();
    run_idle(50, to);
    ck++; if (to || out_log.size() != 1 || {out_log[0].dest, out_log[0].data, out_log[0].last, out_log[0].user} !== {3'd0, 8'h33, 2'b10}) begin fails++; $display("FAIL wd_new_packet: got %0d beats, expected 1 clean beat", out_log.size()); end
    ck++; if (pkt_count_o !== 32'd2) begin fails++; $display("FAIL wd_pkt_after: got %0d, expected 2", pkt_count_o); end
`else
    repeat (40) tick();
    ck++; if (out_log.size() != 1 || m_tvalid !== 1'b0) begin fails++; $display("FAIL nowd_stall: got %0d beats, expected 1 and waiting", out_log.size()); end
    ck++; if (s_tready[0] !== 1'b1) begin fails++; $display("FAIL nowd_still_granted: got %0b, expected 1", s_tready[0]); end
    ck++; if ({timeout_count_o, m_tuser, pkt_count_o} !== 49'h0) begin fails++; $display("FAIL nowd_counters: got %0h, expected 0", {timeout_count_o, m_tuser, pkt_count_o}); end
    src[0].push_back({1'b1, 8'h33});
    drive();
    run_idle(50, to);
    ck++; if (to || out_log.size() != 2 || {out_log[1].dest, out_log[1].data, out_log[1].last, out_log[1].user} !== {3'd0, 8'h33, 2'b10}) begin fails++; $display("FAIL nowd_finish: got %0d beats, expected 2", out_log.size()); end
    ck++; if (pkt_count_o !== 32'd1) begin fails++; $display("FAIL nowd_pkt: got %0d, expected 1", pkt_count_o); end
`endif
  endtask

  task automatic test_reset_mid();
    bit to;
    out_log.delete();
    for (int i = 0; i < 4; i++) src[3].push_back({i == 3, 8'(8'h30 + i)});
    drive();
    for (int i = 0; i < 20 && out_log.size() < 2; i++) tick();
    ck++; if (out_log.size() < 2 || pkt_count_o == 32'd0) begin fails++; $display("FAIL rstmid_setup: got %0d beats, expected 2", out_log.size()); end
    do_reset();
    ck++; if ({m_tvalid, pkt_count_o, timeout_count_o} !== 49'h0) begin fails++; $display("FAIL rstmid_clear: got %0h, expected 0", {m_tvalid, pkt_count_o, timeout_count_o}); end
    src[3].push_back({1'b1, 8'hC3}); src[0].push_back({1'b1, 8'hC0});
    drive();
    run_idle(50, to);
    ck++; if (to || out_log.size() != 2 || {out_log[0].dest, out_log[0].data, out_log[1].dest, out_log[1].data} !== {3'd0, 8'hC0, 3'd3, 8'hC3}) begin fails++; $display("FAIL rstmid_order: got %0d beats, expected ch0 then ch3", out_log.size()); end
    ck++; if ((out_log.size() > 0 && out_log[0].user) || pkt_count_o !== 32'd2) begin fails++; $display("FAIL rstmid_after: got pkt %0d, expected 2 with no terminator", pkt_count_o); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_rr_order();
    test_regrant();
    test_backpressure();
    test_enable();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", ck, fails);
    $finish;
  end
endmodule

// File: doc/surf_stream_merge.md
SURF_STREAM_MERGE -- requirements
Module: surf_stream_merge

Interface
REQ-001 Parameter NCHAN, default 7: number of SURF data input streams, range 2..16.
REQ-002 Parameter DATA_WIDTH, default 8: tdata width of every stream.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: idle-beat limit inside a packet, used only when the watchdog is compiled in.
REQ-004 Clocking and reset SHALL be exactly as decided: one clock; reset is synchronous and active-high.
REQ-005 Port sysclk_i, input, 1: the single clock.
REQ-006 Port rst_i, input, 1: synchronous, active-high reset.
REQ-007 Ports s_tdata / s_tvalid / s_tready / s_tlast, in/in/out/in, NCHAN*DATA_WIDTH / NCHAN / NCHAN / NCHAN: per-channel AXI4S slaves; channel k occupies tdata[k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port enable_i, input, NCHAN: per-channel arbitration enable.
REQ-009 Ports m_tdata / m_tvalid / m_tready / m_tlast, out/out/in/out, DATA_WIDTH / 1 / 1 / 1: merged AXI4S master.
REQ-010 Port m_tdest, output, $clog2(NCHAN): source channel of the current beat.
REQ-011 Port m_tuser, output, 1: 1 on a watchdog-injected terminator beat, else 0.
REQ-012 Port pkt_count_o, output, 32: completed packets emitted; wraps at 2^32.
REQ-013 Port timeout_count_o, output, 16: watchdog terminations; saturates at 16'hFFFF.

Function
REQ-014 The block SHALL forward whole packets (first beat through tlast) from one channel at a time with no interleaving.
REQ-015 The FSM SHALL have states IDLE, PASS, and TERM (TERM exists only with the watchdog compiled in).
REQ-016 In IDLE, the block SHALL select the first channel k with enable_i[k] && s_tvalid[k], searching from grant+1 modulo NCHAN, latch it as grant, and enter PASS on the next cycle; with no candidate it SHALL stay in IDLE.
REQ-017 In PASS, s_tready[grant] SHALL equal (!m_tvalid || m_tready), all other s_tready bits SHALL be 0, and s_tready SHALL be all-zero outside PASS.
REQ-018 The output SHALL be a registered stage: an accepted input beat appears on m_* exactly one cycle later.
REQ-019 m_* SHALL hold stable while m_tvalid && !m_tready.
REQ-020 Acceptance of a beat with s_tlast[grant]=1 SHALL return the FSM to IDLE on the next cycle and increment pkt_count_o when that beat is accepted.
REQ-021 Deasserting enable_i[grant] mid-packet SHALL NOT abort the packet; enable_i affects only IDLE selection.
REQ-022 With a single eligible channel, the block SHALL re-grant that same channel.
REQ-023 Full throughput with m_tready=1 SHALL be one beat per cycle within a packet, plus one IDLE cycle between packets.

Reset
REQ-024 On rst_i, the block SHALL set state=IDLE, grant=NCHAN-1 (so the first search starts at 0), m_tvalid=0, m_tlast=0, m_tdata=0, m_tdest=0, m_tuser=0, s_tready=0, both counters=0, and the watchdog counter=0.
REQ-025 Reset mid-packet SHALL discard the partial packet without emitting a terminator.

Configuration
REQ-026 Macro SURF_STREAM_MERGE_WATCHDOG_EN SHALL compile the watchdog in or out.
REQ-027 With SURF_STREAM_MERGE_WATCHDOG_EN defined, the watchdog counter SHALL run as follows:
  - it counts consecutive PASS cycles with s_tvalid[grant]=0 and clears on any accepted beat;
  - on reaching TIMEOUT_CYCLES, the FSM enters TERM;
  - TERM emits one beat with m_tdata=0, m_tlast=1, m_tuser=1, m_tdest=grant;
  - when that beat is loaded into the output register, the block increments timeout_count_o and pkt_count_o, then returns to IDLE;
  - later beats from the stalled channel are treated as a new packet.
REQ-028 Without SURF_STREAM_MERGE_WATCHDOG_EN, the TERM state and watchdog counter SHALL be absent, m_tuser SHALL be tied 0, timeout_count_o SHALL be tied 0, and PASS SHALL wait indefinitely.

Structure
REQ-029 The shared package surf_stream_pkg SHALL hold the FSM state enum (IDLE, PASS, TERM) and the round-robin next-grant function.
REQ-030 The single sub-module rr_arbiter SHALL take request[NCHAN] and last_grant and produce a combinational next grant and a valid flag.

Verification
REQ-031 After reset, with NCHAN=7: ch2 sends 3 beats AA,BB,CC(last) -> m_tdest=2, data AA,BB,CC, m_tlast on CC, pkt_count_o=1, first beat at output 2 cycles after s_tvalid rises.
REQ-032 Channels 0, 3 and 6 each hold a 2-beat packet, with m_tready=1 -> output order 0, 3, 6, then 0 again if it is refilled; no interleaved beats.
REQ-033 m_tready toggles 1-0-1 every cycle during a 4-beat ch1 packet -> all 4 beats delivered in order, m_* stable during stalls, nothing dropped or duplicated.
REQ-034 enable_i[4]=0 with ch4 and ch5 valid -> ch5 is granted and ch4 is never granted; clearing enable_i[5] mid-packet still completes the ch5 packet.
REQ-035 With the watchdog enabled and TIMEOUT_CYCLES=16: ch0 sends 1 beat (no tlast) and then stalls -> after 16 idle cycles, output beat data=0, tlast=1, tuser=1, tdest=0; timeout_count_o=1, pkt_count_o=1.
REQ-036 rst_i asserted mid-packet on ch3 -> the next cycle shows m_tvalid=0 and counters=0; a subsequent ch0 and ch3 contention grants ch0 first.
